// File: rtl/efuse_pkg.sv
// efuse_pkg: shared constants and state encoding for the efuse program sequencer.
package efuse_pkg;
  localparam int EFUSE_BITS = 256;
  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT_ACK, WAIT_DONE, ERR, FINISH} prog_state_t;
endpackage

// File: rtl/efuse_prog_wdog.sv
// efuse_prog_wdog: saturating per-word watchdog counter.
module efuse_prog_wdog #(
  parameter int TOUT_W = 18,
  parameter logic [TOUT_W-1:0] TOUT = 18'd200000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [TOUT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en && cnt != TOUT) cnt <= cnt + 1'b1;
  // Fires on the enabled cycle whose increment brings the count to TOUT,
  // so a word gets exactly TOUT waiting cycles.
  assign expired = en && (cnt >= TOUT - 1'b1);
endmodule

// File: rtl/efuse_prog_seq.sv
// efuse_prog_seq: splits a 256-bit program request into NW-bit efuse_write
// transactions, skipping masked/zero words, with a per-word timeout.
module efuse_prog_seq
  import efuse_pkg::*;
#(
  parameter int NW = 64,
  parameter int WSEL = EFUSE_BITS / NW,
  parameter int TOUT_W = 18,
  parameter logic [TOUT_W-1:0] TOUT = 18'd200000,
  localparam int SW = $clog2(WSEL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_start,
  input  logic [EFUSE_BITS-1:0] prog_data,
  input  logic [WSEL-1:0]       prog_mask,
  output logic                  prog_busy,
  output logic                  prog_done,
  output logic                  prog_err,
  output logic [SW-1:0]         prog_err_sel,
  output logic [SW-1:0]         write_sel,
  output logic [NW-1:0]         write_data,
  output logic                  write_start,
  input  logic                  busy_write,
  input  logic                  write_done
);
  localparam logic [SW:0] IDX_END = (SW+1)'(WSEL);
  prog_state_t st, nxt;
  logic [SW:0] idx;
  logic [EFUSE_BITS-1:0] data_q;
  logic [WSEL-1:0] mask_q;
  logic [NW-1:0] word;
  logic hit, expired;
  assign word = data_q[idx[SW-1:0]*NW +: NW];
  assign hit = (idx != IDX_END) && mask_q[idx[SW-1:0]] && (word != '0);
  efuse_prog_wdog #(.TOUT_W(TOUT_W), .TOUT(TOUT)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clear(st == ISSUE),
    .en(st == WAIT_ACK || st == WAIT_DONE),
    .expired(expired)
  );
  // write_done is a stale level from the previous word, so WAIT_ACK keys only
  // on busy_write; completion is checked before the timeout in each wait state.
  always_comb begin
    nxt = st;
    case (st)
      IDLE:      nxt = prog_start ? SCAN : IDLE;
      SCAN:      nxt = (idx == IDX_END) ? FINISH : (hit ? ISSUE : SCAN);
      ISSUE:     nxt = WAIT_ACK;
      WAIT_ACK:  nxt = busy_write ? WAIT_DONE : (expired ? ERR : WAIT_ACK);
      WAIT_DONE: nxt = (!busy_write && write_done) ? SCAN : (expired ? ERR : WAIT_DONE);
      ERR:       nxt = FINISH;
      FINISH:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st           <= IDLE;
      idx          <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      write_sel    <= '0;
      write_data   <= '0;
      prog_err     <= 1'b0;
      prog_err_sel <= '0;
    end else begin
      st <= nxt;
      if (st == IDLE && prog_start) begin
        data_q   <= prog_data;
        mask_q   <= prog_mask;
        idx      <= '0;
        prog_err <= 1'b0;
      end
      if ((st == SCAN || st == WAIT_DONE) && nxt == SCAN) idx <= idx + 1'b1;
      if (st == SCAN && nxt == ISSUE) begin
        write_sel  <= idx[SW-1:0];
        write_data <= word;
      end
      if (st == ERR) begin
        prog_err     <= 1'b1;
        prog_err_sel <= idx[SW-1:0];
      end
    end
  assign prog_busy   = st != IDLE;
  assign prog_done   = st == FINISH;
  assign write_start = st == ISSUE;
endmodule

// File: tb/tb_efuse_prog_seq.sv
// tb_efuse_prog_seq: table-driven and directed checks of efuse_prog_seq
// against a small efuse_write responder model.
module tb_efuse_prog_seq;
  logic clk = 0, rst = 1, prog_start = 0;
  logic [255:0] prog_data = '0;
  logic [3:0] prog_mask = '0;
  logic prog_busy, prog_done, prog_err, write_start;
  logic [1:0] prog_err_sel, write_sel;
  logic [63:0] write_data;
  logic busy_write = 0, write_done = 0;
  int checks = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  efuse_prog_seq #(.TOUT(18'd50)) dut (
    .clk(clk), .rst(rst), .prog_start(prog_start), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_busy(prog_busy), .prog_done(prog_done),
    .prog_err(prog_err), .prog_err_sel(prog_err_sel), .write_sel(write_sel),
    .write_data(write_data), .write_start(write_start),
    .busy_write(busy_write), .write_done(write_done)
  );
  always @(posedge clk) cyc++;
  bit model_en = 1, clr_done = 1, active = 0;
  int ack_dly = 1, bsy_len = 20, mcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      active = 0; busy_write = 0; write_done = 0;
    end else if (write_start && model_en) begin
      active = 1; mcnt = 0;
      if (clr_done) write_done = 0;
    end else if (active) begin
      mcnt++;
      if (mcnt == ack_dly) busy_write = 1;
      if (mcnt == ack_dly + bsy_len) begin
        busy_write = 0; write_done = 1; active = 0;
      end
    end
  end
  int starts = 0, dones = 0, done_cyc = 0, req_cyc = 0;
  int sel_log [64];
  int start_cyc [64];
  logic [63:0] data_log [64];
  always @(negedge clk) begin
    if (write_start && starts < 64) begin
      sel_log[starts] = write_sel; data_log[starts] = write_data;
      start_cyc[starts] = cyc; starts++;
    end
    if (prog_done) begin dones++; done_cyc = cyc; end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic req(input logic [3:0] m, input logic [255:0] d);
    @(negedge clk);
    prog_mask = m; prog_data = d; prog_start = 1; req_cyc = cyc;
    @(negedge clk);
    prog_start = 0;
  endtask
  task automatic wait_done(input int db, input int budget);
    int k = 0;
    while (dones == db && k < budget) begin @(negedge clk); k++; end
    chk("done_seen", 64'(dones != db), 64'd1);
  endtask
  typedef struct {
    logic [3:0]   mask;
    logic [255:0] data;
    int           n;
    logic [7:0]   sels;
  } vec_t;
  vec_t tbl [6];
  initial begin
    int sb, db;
    tbl[0] = '{4'hF, {64'h8000_0000_0000_0005, 64'h0, 64'h3, 64'h1}, 3, {2'd0, 2'd3, 2'd1, 2'd0}};
    tbl[1] = '{4'b1010, {64'h4, 64'h3, 64'h2, 64'h1}, 2, {4'd0, 2'd3, 2'd1}};
    tbl[2] = '{4'hF, {192'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 1, 8'd0};
    tbl[3] = '{4'h0, {256{1'b1}}, 0, 8'd0};
    tbl[4] = '{4'hF, 256'h0, 0, 8'd0};
    tbl[5] = '{4'b1000, {64'hDEAD, 64'h0, 64'h5, 64'h6}, 1, {6'd0, 2'd3}};
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(prog_busy), 0);
    chk("rst_done", 64'(prog_done), 0);
    chk("rst_err", 64'(prog_err), 0);
    chk("rst_err_sel", 64'(prog_err_sel), 0);
    chk("rst_sel", 64'(write_sel), 0);
    chk("rst_data", write_data, 0);
    chk("rst_start", 64'(write_start), 0);
    rst = 0;
    for (int v = 0; v < 6; v++) begin
      sb = starts; db = dones;
      req(tbl[v].mask, tbl[v].data);
      wait_done(db, 400);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_nstarts", v), 64'(starts - sb), 64'(tbl[v].n));
      for (int i = 0; i < tbl[v].n; i++) begin
        int es;
        es = int'(tbl[v].sels[2*i +: 2]);
        chk($sformatf("v%0d_sel%0d", v, i), 64'(sel_log[sb+i]), 64'(es));
        chk($sformatf("v%0d_data%0d", v, i), data_log[sb+i], tbl[v].data[es*64 +: 64]);
      end
      chk($sformatf("v%0d_ndone", v), 64'(dones - db), 1);
      chk($sformatf("v%0d_err", v), 64'(prog_err), 0);
      chk($sformatf("v%0d_idle", v), 64'(prog_busy), 0);
    end
    // Empty request: SCAN walks all WSEL+1 positions, then FINISH.
    sb = starts; db = dones;
    req(4'h0, {256{1'b1}});
    chk("zero_busy", 64'(prog_busy), 1);
    wait_done(db, 50);
    chk("zero_latency", 64'(done_cyc - req_cyc), 6);
    chk("zero_nstarts", 64'(starts - sb), 0);
    // Stale write_done held high: must wait for busy_write rise and fall.
    clr_done = 0; ack_dly = 4; bsy_len = 6;
    sb = starts; db = dones;
    req(4'b0011, {128'h0, 64'h22, 64'h11});
    wait_done(db, 200);
    chk("stale_nstarts", 64'(starts - sb), 2);
    chk("stale_gap", 64'(start_cyc[sb+1] - start_cyc[sb]), 12);
    chk("stale_sel1", 64'(sel_log[sb+1]), 1);
    clr_done = 1; ack_dly = 1; bsy_len = 20;
    // Timeout with a stale done level, plus an ignored prog_start while busy.
    model_en = 0;
    sb = starts; db = dones;
    req(4'h1, {192'h0, 64'hAB});
    repeat (5) @(negedge clk);
    prog_mask = 4'hF; prog_data = {256{1'b1}}; prog_start = 1;
    @(negedge clk);
    prog_start = 0;
    wait_done(db, 200);
    chk("tout_latency", 64'(done_cyc - start_cyc[sb]), 52);
    chk("tout_err", 64'(prog_err), 1);
    chk("tout_err_sel", 64'(prog_err_sel), 0);
    chk("tout_data", data_log[sb], 64'hAB);
    repeat (20) @(negedge clk);
    chk("tout_nstarts", 64'(starts - sb), 1);
    chk("tout_ndone", 64'(dones - db), 1);
    chk("tout_err_sticky", 64'(prog_err), 1);
    // Restart after error clears prog_err and programs normally.
    model_en = 1;
    sb = starts; db = dones;
    req(4'b0100, {64'h0, 64'h77, 128'h0});
    chk("restart_err_clr", 64'(prog_err), 0);
    wait_done(db, 200);
    chk("restart_nstarts", 64'(starts - sb), 1);
    chk("restart_sel", 64'(sel_log[sb]), 2);
    chk("restart_err", 64'(prog_err), 0);
    // Reset in WAIT_DONE of word 1.
    sb = starts;
    req(4'hF, {64'h4, 64'h3, 64'h2, 64'h1});
    for (int k = 0; k < 200 && starts - sb < 2; k++) @(negedge clk);
    chk("rstmid_reach", 64'(starts - sb), 2);
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    chk("rstmid_start", 64'(write_start), 0);
    chk("rstmid_busy", 64'(prog_busy), 0);
    @(posedge clk); #1;
    chk("rstmid_sel", 64'(write_sel), 0);
    chk("rstmid_data", write_data, 0);
    chk("rstmid_done", 64'(prog_done), 0);
    chk("rstmid_err", 64'(prog_err), 0);
    @(negedge clk);
    rst = 0;
    repeat (80) @(negedge clk);
    chk("rstmid_nstarts", 64'(starts - sb), 2);
    chk("rstmid_idle", 64'(prog_busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
